jesd204b_dl_framemark_gen: RTL

Parametrised frame/multiframe marker generator for the JESD204B data link layer. It starts on the first LMFC pulse and emits per-octet start/end-of-frame and start/end-of-multiframe flags for every beat of a lane datapath of configurable width. It supports any F and K whose multiframe length is a whole number of beats. It checks each later LMFC pulse against its own multiframe position and sits between the LMFC generator and the lane character-replacement / ILAS logic.

---
 rtl/jesd204b_dl_framemark_gen_if.sv | 30 +++
 rtl/jesd204b_dl_framemark_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/jesd204b_dl_framemark_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : jesd204b_dl_framemark_gen_if
// Brief    : LMFC/enable inputs and per-octet frame/multiframe marker outputs
//            of the JESD204B data-link frame marker generator.
// Revision : 1.0 - initial release
// ============================================================================
interface jesd204b_dl_framemark_gen_if #(
    parameter int OCTETS_PER_BEAT = 4
) ();
    logic                       lmfc;
    logic                       enable;
    logic [OCTETS_PER_BEAT-1:0] sof;
    logic [OCTETS_PER_BEAT-1:0] eof;
    logic [OCTETS_PER_BEAT-1:0] som;
    logic [OCTETS_PER_BEAT-1:0] eom;
    logic                       marker_valid;
    logic                       lmfc_err;

    modport master (
        input  lmfc, enable,
        output sof, eof, som, eom, marker_valid, lmfc_err
    );

    modport slave (
        output lmfc, enable,
        input  sof, eof, som, eom, marker_valid, lmfc_err
    );
endinterface
`default_nettype wire

// File: rtl/jesd204b_dl_framemark_gen.sv
`default_nettype none
// ============================================================================
// Module   : jesd204b_dl_framemark_gen
// Brief    : JESD204B per-octet SOF/EOF/SOM/EOM marker generator started by
//            LMFC. Optional macro JESD204B_FM_REALIGN_EN realigns on a
//            misaligned LMFC pulse instead of only flagging it.
// Revision : 1.0 - initial release
// ============================================================================
module jesd204b_dl_framemark_gen #(
    parameter int OCTETS_PER_BEAT = 4,
    parameter int OCTETS_PER_FR   = 5,
    parameter int FRAMES_PER_MF   = 4,
    parameter int PIPE_STAGES     = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    jesd204b_dl_framemark_gen_if.master   fm
);
    localparam int c_B     = OCTETS_PER_BEAT;
    localparam int c_M     = OCTETS_PER_FR * FRAMES_PER_MF;
    localparam int c_FW    = $clog2(OCTETS_PER_FR + c_B) + 1;
    localparam int c_PW    = $clog2(c_M + c_B) + 1;
    localparam int c_BUS_W = 4 * c_B + 2;

    localparam logic [c_FW-1:0] c_F_W      = c_FW'(OCTETS_PER_FR);
    localparam logic [c_FW-1:0] c_F_LAST   = c_FW'(OCTETS_PER_FR - 1);
    localparam logic [c_PW-1:0] c_M_W      = c_PW'(c_M);
    localparam logic [c_PW-1:0] c_B_P      = c_PW'(c_B);
    localparam logic [c_PW-1:0] c_P_LAST   = c_PW'(c_M - c_B);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    if ((c_M % c_B) != 0) begin : g_bad_mf_len
        $error("F*K must be a multiple of OCTETS_PER_BEAT");
    end
    if (!(c_B == 1 || c_B == 2 || c_B == 4 || c_B == 8)) begin : g_bad_beat
        $error("OCTETS_PER_BEAT must be 1, 2, 4 or 8");
    end

    // Values here are always below F + B, so B subtractions suffice (F=1, B=8 worst case).
    function automatic logic [c_FW-1:0] f_mod_f(input logic [c_FW-1:0] v);
        logic [c_FW-1:0] r;
        r = v;
        for (int k = 0; k < c_B; k++) begin
            if (r >= c_F_W) r = r - c_F_W;
        end
        return r;
    endfunction

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [c_PW-1:0] r_p;
    logic [c_PW-1:0] w_p_sum;
    logic [c_PW-1:0] w_p_adv;
    logic [c_PW-1:0] w_beat_p;
    logic [c_FW-1:0] r_fo;
    logic [c_FW-1:0] w_fo_adv;
    logic [c_FW-1:0] w_beat_fo;
    logic [c_FW-1:0] w_bit_fo [c_B];
    logic            w_active;
    logic            w_misalign;
    logic [c_B-1:0]  w_sof;
    logic [c_B-1:0]  w_eof;
    logic [c_B-1:0]  w_som;
    logic [c_B-1:0]  w_eom;
    logic [c_BUS_W-1:0] r_core;
    logic [c_BUS_W-1:0] w_out;

    assign w_p_sum  = r_p + c_B_P;
    assign w_p_adv  = (w_p_sum >= c_M_W) ? (w_p_sum - c_M_W) : w_p_sum;
    assign w_fo_adv = f_mod_f(r_fo + c_FW'(c_B));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= c_ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (fm.enable && fm.lmfc) w_state_next = c_ST_RUN;
            c_ST_RUN:  if (!fm.enable)           w_state_next = c_ST_IDLE;
            default:                             w_state_next = c_ST_IDLE;
        endcase
    end

    // Beat position chosen here is the one loaded into the core register at this edge.
    always_comb begin
        w_active   = 1'b0;
        w_misalign = 1'b0;
        w_beat_p   = '0;
        w_beat_fo  = '0;
        case (r_state)
            c_ST_IDLE: w_active = fm.enable && fm.lmfc;
            c_ST_RUN: begin
                w_active   = fm.enable;
                w_misalign = fm.enable && fm.lmfc && (w_p_adv != '0);
                if (fm.enable) begin
                    w_beat_p  = w_p_adv;
                    w_beat_fo = w_fo_adv;
                end
`ifdef JESD204B_FM_REALIGN_EN
                if (w_misalign) begin
                    w_beat_p  = '0;
                    w_beat_fo = '0;
                end
`endif
            end
            default: w_active = 1'b0;
        endcase
    end

    always_comb begin
        w_sof = '0;
        w_eof = '0;
        w_som = '0;
        w_eom = '0;
        for (int i = 0; i < c_B; i++) begin
            w_bit_fo[i] = f_mod_f(w_beat_fo + c_FW'(i));
            w_sof[i]    = w_active && (w_bit_fo[i] == '0);
            w_eof[i]    = w_active && (w_bit_fo[i] == c_F_LAST);
        end
        w_som[0]     = w_active && (w_beat_p == '0);
        w_eom[c_B-1] = w_active && (w_beat_p == c_P_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p    <= '0;
            r_fo   <= '0;
            r_core <= '0;
        end else begin
            r_p    <= w_beat_p;
            r_fo   <= w_beat_fo;
            r_core <= {w_active, w_misalign, w_eom, w_som, w_eof, w_sof};
        end
    end

    if (PIPE_STAGES == 0) begin : g_nopipe
        assign w_out = r_core;
    end else begin : g_pipe
        logic [c_BUS_W-1:0] r_pipe [PIPE_STAGES];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int s = 0; s < PIPE_STAGES; s++) r_pipe[s] <= '0;
            end else begin
                r_pipe[0] <= r_core;
                for (int s = 1; s < PIPE_STAGES; s++) r_pipe[s] <= r_pipe[s-1];
            end
        end
        assign w_out = r_pipe[PIPE_STAGES-1];
    end

    assign {fm.marker_valid, fm.lmfc_err, fm.eom, fm.som, fm.eof, fm.sof} = w_out;

endmodule
`default_nettype wire
